// File: rtl/weight_chain_sequencer.sv
// -----------------------------------------------------------------------------
// weight_chain_sequencer
//
// Head/tail sequencer for a chain of UNIT_COUNT weight-compute cells.
// Input vectors arrive as CHUNK_COUNT beats of INPUT_AMOUNT packed values.
// Each accepted beat is issued into the first cell with a sequential chunk
// index. Flagged results leaving the last cell are captured into a result
// FIFO. The chain has no backpressure, so a vector is only started when the
// FIFO has room reserved for all of its UNIT_COUNT results (credit gating).
//
// Optional feature: define WSEQ_TIMEOUT_EN to add a watchdog that abandons
// outstanding results after TIMEOUT quiet cycles and flags an error.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input beat handshake, in_data packed values (lane 0 LSBs)
//   chain_index       chunk index sent to the first cell
//   chain_value       values sent to the first cell
//   chain_enable      beat valid to the first cell
//   chain_result      result injected into the first cell (always 0)
//   chain_out_result  result leaving the last cell, MSB is the valid flag
//   res_valid/ready   result FIFO head handshake
//   res_data/res_last FIFO head value and end-of-vector tag
//   busy              vector open or results outstanding
//   err               sticky error (unexpected result or watchdog expiry)
// -----------------------------------------------------------------------------
module weight_chain_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int INDEX_WIDTH  = 10,
  parameter int INPUT_AMOUNT = 4,
  parameter int CHUNK_COUNT  = 4,
  parameter int UNIT_COUNT   = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [INPUT_AMOUNT*DATA_WIDTH-1:0]   in_data,
  output logic [INDEX_WIDTH-1:0]               chain_index,
  output logic [INPUT_AMOUNT*DATA_WIDTH-1:0]   chain_value,
  output logic                                 chain_enable,
  output logic [RESULT_WIDTH:0]                chain_result,
  input  logic [RESULT_WIDTH:0]                chain_out_result,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [RESULT_WIDTH-1:0]              res_data,
  output logic                                 res_last,
  output logic                                 busy,
  output logic                                 err
);

  localparam int VW = INPUT_AMOUNT * DATA_WIDTH;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int UW = (UNIT_COUNT > 1) ? $clog2(UNIT_COUNT) : 1;

  localparam logic [CW:0]            LP_ROOM       = (CW+1)'(FIFO_DEPTH - UNIT_COUNT);
  localparam logic [CW-1:0]          LP_UNITS      = CW'(UNIT_COUNT);
  localparam logic [INDEX_WIDTH-1:0] LP_LAST_CHUNK = INDEX_WIDTH'(CHUNK_COUNT - 1);
  localparam logic [AW-1:0]          LP_LAST_PTR   = AW'(FIFO_DEPTH - 1);
  localparam logic [UW-1:0]          LP_LAST_UNIT  = UW'(UNIT_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_WAIT
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                   r_state;
  logic [INDEX_WIDTH-1:0]   r_chunk_cnt;
  logic [CW-1:0]            r_pending;
  logic [CW-1:0]            r_occ;
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [UW-1:0]            r_push_cnt;
  logic [RESULT_WIDTH:0]    r_mem [FIFO_DEPTH];
  logic                     r_in_ready;
  logic [INDEX_WIDTH-1:0]   r_chain_index;
  logic [VW-1:0]            r_chain_value;
  logic                     r_chain_enable;
  logic                     r_res_valid;
  logic [RESULT_WIDTH-1:0]  r_res_data;
  logic                     r_res_last;
  logic                     r_err;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  state_t                   w_state_nxt;
  logic                     w_accept;
  logic                     w_first;
  logic                     w_close;
  logic                     w_flag;
  logic                     w_push;
  logic                     w_drop;
  logic                     w_pop;
  logic                     w_push_last;
  logic                     w_timeout;
  logic [CW-1:0]            w_pending_nxt;
  logic [CW-1:0]            w_occ_nxt;
  logic [CW:0]              w_used_nxt;
  logic                     w_in_ready_nxt;
  logic [AW-1:0]            w_rd_ptr_nxt;
  logic [RESULT_WIDTH:0]    w_push_entry;
  logic [RESULT_WIDTH:0]    w_head_nxt;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LP_LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  assign w_accept     = in_valid & r_in_ready;
  assign w_first      = w_accept & (r_state != S_ACTIVE);
  assign w_close      = w_accept & (r_chunk_cnt == LP_LAST_CHUNK);
  assign w_flag       = chain_out_result[RESULT_WIDTH];
  // A flagged result is only legal against a reserved FIFO slot.
  assign w_push       = w_flag & (r_pending != '0);
  assign w_drop       = w_flag & (r_pending == '0);
  assign w_pop        = res_ready & r_res_valid;
  assign w_push_last  = (r_push_cnt == LP_LAST_UNIT);
  assign w_push_entry = {w_push_last, chain_out_result[RESULT_WIDTH-1:0]};

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef WSEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LP_WD_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_wd_cnt;
  logic          w_wd_run;

  // Quiet cycles are counted from the last chain activity: an issued beat
  // or an arriving result restarts the count.
  assign w_wd_run  = (r_pending != '0) & ~w_flag & ~w_accept;
  assign w_timeout = w_wd_run & (r_wd_cnt == LP_WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (!w_wd_run || w_timeout) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + TW'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Credit bookkeeping
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_timeout) begin
      w_pending_nxt = '0;
    end else if (w_push) begin
      w_pending_nxt = r_pending - CW'(1);
    end
    // Combined first-beat accept and push nets to UNIT_COUNT-1.
    if (w_first) begin
      w_pending_nxt = w_pending_nxt + LP_UNITS;
    end
  end

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + CW'(1);
      2'b01:   w_occ_nxt = r_occ - CW'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  // A push converts a reserved slot into an occupied one, so only pops and
  // new reservations move the used total.
  assign w_used_nxt     = {1'b0, w_occ_nxt} + {1'b0, w_pending_nxt};
  assign w_in_ready_nxt = (w_state_nxt == S_ACTIVE) | (w_used_nxt <= LP_ROOM);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_WAIT: begin
        if (w_accept) begin
          // Only a single-beat vector closes on its first beat.
          w_state_nxt = w_close ? S_WAIT : S_ACTIVE;
        end else if (w_pending_nxt == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (w_close) begin
          w_state_nxt = (w_pending_nxt == '0) ? S_IDLE : S_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue side and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chunk_cnt    <= '0;
      r_pending      <= '0;
      r_in_ready     <= 1'b0;
      r_chain_index  <= '0;
      r_chain_value  <= '0;
      r_chain_enable <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_pending      <= w_pending_nxt;
      r_in_ready     <= w_in_ready_nxt;
      r_chain_enable <= w_accept;
      // Gap cycles drive zeros so the first cell sees a clean idle bus.
      r_chain_index  <= w_accept ? r_chunk_cnt : '0;
      r_chain_value  <= w_accept ? in_data : '0;
      if (w_accept) begin
        r_chunk_cnt <= w_close ? '0 : r_chunk_cnt + INDEX_WIDTH'(1);
      end
      if (w_drop || w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_ptr_nxt = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_head_nxt   = '0;
    if (w_occ_nxt != '0) begin
      // When the next head is the slot being written this cycle, bypass the
      // array so the head register sees the new entry immediately.
      if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
        w_head_nxt = w_push_entry;
      end else begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
      end
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read after
  // being written, and leaving it out keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_push_cnt  <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_last  <= 1'b0;
    end else begin
      r_occ       <= w_occ_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_res_valid <= (w_occ_nxt != '0);
      r_res_last  <= w_head_nxt[RESULT_WIDTH];
      r_res_data  <= w_head_nxt[RESULT_WIDTH-1:0];
      if (w_push) begin
        r_wr_ptr   <= ptr_inc(r_wr_ptr);
        r_push_cnt <= w_push_last ? '0 : r_push_cnt + UW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready     = r_in_ready;
  assign chain_index  = r_chain_index;
  assign chain_value  = r_chain_value;
  assign chain_enable = r_chain_enable;
  assign chain_result = '0;
  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign res_last     = r_res_last;
  assign busy         = (r_state != S_IDLE);
  assign err          = r_err;

endmodule

// File: tb/tb_weight_chain_sequencer.sv
// -----------------------------------------------------------------------------
// tb_weight_chain_sequencer
//
// Directed bench for weight_chain_sequencer with default parameters and
// TIMEOUT=16. The bench plays the role of the cell chain by driving
// chain_out_result directly. With WSEQ_TIMEOUT_EN defined, the watchdog
// scenario is also exercised.
// -----------------------------------------------------------------------------
module tb_weight_chain_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [9:0]  chain_index;
  logic [31:0] chain_value;
  logic        chain_enable;
  logic [16:0] chain_result;
  logic [16:0] chain_out_result = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_last;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  weight_chain_sequencer #(
    .DATA_WIDTH  (8),
    .RESULT_WIDTH(16),
    .INDEX_WIDTH (10),
    .INPUT_AMOUNT(4),
    .CHUNK_COUNT (4),
    .UNIT_COUNT  (4),
    .FIFO_DEPTH  (8),
    .TIMEOUT     (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .chain_index     (chain_index),
    .chain_value     (chain_value),
    .chain_enable    (chain_enable),
    .chain_result    (chain_result),
    .chain_out_result(chain_out_result),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .res_last        (res_last),
    .busy            (busy),
    .err             (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat; it must be accepted and appear on chain_* one cycle later.
  task automatic send_beat(input string tag, input logic [9:0] idx, input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    check({tag, "_rdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    check({tag, "_en"},  chain_enable, 1);
    check({tag, "_idx"}, chain_index, idx);
    check({tag, "_val"}, chain_value, d);
  endtask

  task automatic push_res(input logic [15:0] v);
    chain_out_result = {1'b1, v};
    tick();
    chain_out_result = '0;
  endtask

  task automatic pop_check(input string tag, input logic [15:0] d, input logic last);
    check({tag, "_vld"},  res_valid, 1);
    check({tag, "_data"}, res_data, d);
    check({tag, "_last"}, res_last, last);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_chain_en", chain_enable, 0);
    check("rst_chain_idx", chain_index, 0);
    check("rst_chain_val", chain_value, 0);
    check("rst_chain_res", chain_result, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_last", res_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);

    // ---------------- one vector, no gaps ----------------
    for (int i = 0; i < 4; i++) begin
      send_beat("v1", 10'(i), 32'h0403_0201 + 32'(i) * 32'h0404_0404);
      check("v1_busy", busy, 1);
    end
    tick();
    check("v1_gap_en", chain_enable, 0);
    check("v1_gap_idx", chain_index, 0);
    check("v1_wait_busy", busy, 1);
    push_res(16'd10);
    check("v1_first_vld", res_valid, 1);
    check("v1_first_data", res_data, 16'd10);
    check("v1_first_last", res_last, 0);
    push_res(16'd20);
    push_res(16'd30);
    check("v1_busy_before_last", busy, 1);
    push_res(16'd40);
    check("v1_busy_after_last", busy, 0);
    pop_check("v1_pop10", 16'd10, 0);
    pop_check("v1_pop20", 16'd20, 0);
    pop_check("v1_pop30", 16'd30, 0);
    pop_check("v1_pop40", 16'd40, 1);
    check("v1_empty", res_valid, 0);

    // ---------------- credit gating with stalled consumer ----------------
    for (int i = 0; i < 4; i++) send_beat("cg_a", 10'(i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) send_beat("cg_b", 10'(i), 32'hB000_0000 + 32'(i));
    check("cg_busy", busy, 1);
    in_valid = 1'b1;
    in_data  = 32'hC000_0000;
    for (int i = 0; i < 3; i++) begin
      check("cg_blocked_rdy", in_ready, 0);
      tick();
      check("cg_blocked_en", chain_enable, 0);
    end
    for (int i = 0; i < 8; i++) begin
      push_res(16'(101 + i));
      check("cg_push_rdy", in_ready, 0);
      check("cg_push_en", chain_enable, 0);
    end
    check("cg_drained_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      check("cg_pre_pop_rdy", in_ready, 0);
      pop_check("cg_pop_a", 16'(101 + i), i == 3);
    end
    check("cg_freed_rdy", in_ready, 1);
    check("cg_freed_en", chain_enable, 0);
    send_beat("cg_c", 10'd0, 32'hC000_0000);
    for (int i = 1; i < 4; i++) send_beat("cg_c", 10'(i), 32'hC000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) push_res(16'(201 + i));
    for (int i = 0; i < 4; i++) pop_check("cg_pop_b", 16'(105 + i), i == 3);
    for (int i = 0; i < 4; i++) pop_check("cg_pop_c", 16'(201 + i), i == 3);
    check("cg_empty", res_valid, 0);
    check("cg_err", err, 0);

    // ---------------- gap inside a vector ----------------
    send_beat("gap", 10'd0, 32'h1111_1111);
    send_beat("gap", 10'd1, 32'h2222_2222);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gap_en", chain_enable, 0);
      check("gap_idx", chain_index, 0);
      check("gap_val", chain_value, 0);
      check("gap_rdy", in_ready, 1);
      check("gap_busy", busy, 1);
    end
    send_beat("gap", 10'd2, 32'h3333_3333);
    send_beat("gap", 10'd3, 32'h4444_4444);

    // ---------------- simultaneous push and pop at occupancy 3 ----------------
    push_res(16'd1);
    push_res(16'd2);
    push_res(16'd3);
    check("pp_head_before", res_data, 16'd1);
    chain_out_result = {1'b1, 16'd4};
    res_ready = 1'b1;
    tick();
    chain_out_result = '0;
    res_ready = 1'b0;
    pop_check("pp_pop2", 16'd2, 0);
    pop_check("pp_pop3", 16'd3, 0);
    pop_check("pp_pop4", 16'd4, 1);
    check("pp_empty", res_valid, 0);
    check("pp_busy", busy, 0);

    // ---------------- unexpected result ----------------
    check("unexp_err_before", err, 0);
    push_res(16'hDEAD);
    check("unexp_err", err, 1);
    check("unexp_dropped", res_valid, 0);
    check("unexp_busy", busy, 0);
    repeat (3) tick();
    check("unexp_err_sticky", err, 1);
    check("unexp_rdy", in_ready, 1);
    rst_n = 1'b0;
    #2;
    check("rst2_err", err, 0);
    check("rst2_rdy", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst2_rdy_after", in_ready, 1);
    check("rst2_err_after", err, 0);

`ifdef WSEQ_TIMEOUT_EN
    // ---------------- watchdog ----------------
    begin
      int n;
      for (int i = 0; i < 4; i++) send_beat("wd", 10'(i), 32'h5555_0000 + 32'(i));
      n = 0;
      while (!err && n < 40) begin
        tick();
        n++;
      end
      check("wd_cycles", 64'(n), 64'd16);
      check("wd_err", err, 1);
      check("wd_busy", busy, 0);
      tick();
      check("wd_rdy", in_ready, 1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_chain_sequencer.md
# weight_chain_sequencer

Sequencer at the head and tail of a chain of `UNIT_COUNT` weight-compute cells. It accepts input vectors as `CHUNK_COUNT` beats of `INPUT_AMOUNT` packed values. It drives each beat into the first cell with a sequential chunk index. It captures the flagged results leaving the last cell into a result FIFO. Issue is credit-gated so the FIFO can never overflow, because the systolic chain has no backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of one input value
- `RESULT_WIDTH`, 16, width of one result (the chain result bus is `RESULT_WIDTH+1`; the MSB is the valid flag)
- `INDEX_WIDTH`, 10, chunk index width
- `INPUT_AMOUNT`, 4, values per beat
- `CHUNK_COUNT`, 4, beats per vector (weights per unit / `INPUT_AMOUNT`)
- `UNIT_COUNT`, 4, cells in the chain, which is also the number of results per vector
- `FIFO_DEPTH`, 8, result FIFO entries; must satisfy `FIFO_DEPTH >= UNIT_COUNT`
- `TIMEOUT`, 1024, watchdog cycles; used only when `WSEQ_TIMEOUT_EN` is defined

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat accepted when high together with `in_valid`
- `in_data`  in  `INPUT_AMOUNT*DATA_WIDTH`  packed input values; lane 0 is in the LSBs
- `chain_index`  out  `INDEX_WIDTH`  chunk index sent to the first cell
- `chain_value`  out  `INPUT_AMOUNT*DATA_WIDTH`  values sent to the first cell
- `chain_enable`  out  1  beat valid to the first cell
- `chain_result`  out  `RESULT_WIDTH+1`  result injected into the first cell; constant 0
- `chain_out_result`  in  `RESULT_WIDTH+1`  result leaving the last cell; bit `RESULT_WIDTH` = valid
- `res_valid`  out  1  FIFO head valid
- `res_ready`  in  1  consumer pops the FIFO head
- `res_data`  out  `RESULT_WIDTH`  result value at the FIFO head
- `res_last`  out  1  head is the `UNIT_COUNT`-th result of its vector
- `busy`  out  1  a vector is open or results are still outstanding
- `err`  out  1  sticky error flag; cleared only by reset

## Operation
- State machine:
  - `IDLE`: no vector open.
  - `ACTIVE`: vector open, `chunk_cnt` in 1..`CHUNK_COUNT-1`.
  - `WAIT`: no vector open, `pending > 0`.
- Credits: `credit = FIFO_DEPTH - occupancy - pending`.
- `in_ready`:
  - In `ACTIVE`: always 1.
  - In `IDLE`/`WAIT`: 1 only when `credit >= UNIT_COUNT`.
- First beat of a vector:
  - Accepted from `IDLE`/`WAIT`.
  - `pending += UNIT_COUNT`.
  - Beat is issued with index 0.
  - Goes to `ACTIVE`, or stays/returns to `WAIT` if `CHUNK_COUNT == 1`.
- Each accepted beat is issued on `chain_*` with `chain_index = chunk_cnt`, then `chunk_cnt` increments.
- Beat with index `CHUNK_COUNT-1` closes the vector: `chunk_cnt` wraps to 0 and the FSM goes to `WAIT`.
- Gaps between beats of an open vector are legal. In a gap cycle `chain_enable`, `chain_index` and `chain_value` are 0.
- Result capture:
  - Each cycle with `chain_out_result[RESULT_WIDTH]` = 1 pushes the low `RESULT_WIDTH` bits into the FIFO and does `pending -= 1`.
  - `res_last` is tagged from a push counter that runs modulo `UNIT_COUNT`.
- `WAIT` → `IDLE` when `pending` reaches 0 with no vector open.
- A flagged result arriving with `pending == 0` is dropped and sets `err`.
- Simultaneous push and pop: occupancy is unchanged and the data order is preserved.
- Simultaneous first-beat accept and result push: `pending` changes by `UNIT_COUNT - 1`.
- `busy = (state != IDLE)`.

## Timing
- Reset, asynchronous, all outputs low:
  - `in_ready` = 0
  - `chain_index`, `chain_value`, `chain_enable`, `chain_result` = 0
  - `res_valid`, `res_data`, `res_last` = 0
  - `busy` = 0, `err` = 0
  - FIFO empty, counters 0, state `IDLE`.
- `in_ready` is driven in the first cycle after `rst_n` deasserts, since credit = `FIFO_DEPTH` and the state is `IDLE`.
- Reset asserted mid-vector or mid-drain discards all state. Results still travelling in the chain after reset count as unexpected and set `err`; the bench holds reset until the chain is empty.
- `chain_*` outputs are registered: 1 cycle from the input handshake to `chain_enable`.
- Result push → `res_valid` high the next cycle. `res_data` and `res_last` are registered FIFO-head outputs.
- `in_ready` is registered from the next-cycle credit.
  - A pop frees credit 1 cycle later.
  - A push does not change credit (the reserved slot becomes an occupied slot).

## Configuration
- `WSEQ_TIMEOUT_EN` defined:
  - A watchdog counts cycles while `pending > 0` and no flagged result arrives.
  - Any arrival resets the count.
  - On reaching `TIMEOUT`: `pending` is cleared, `err` is set, and the FSM goes to `IDLE` if no vector is open (otherwise it stays `ACTIVE`).
- Undefined: no watchdog logic, and `TIMEOUT` is unused.

## Test plan
- Default params, one vector of 4 beats with no gaps → `chain_index` 0,1,2,3 on consecutive cycles 1 cycle after each handshake. Model chain returns 4 flagged results 10,20,30,40 → FIFO outputs 10,20,30,40 with `res_last` only on 40. `busy` falls after the last push.
- `FIFO_DEPTH`=8, `res_ready`=0, stream 3 vectors → 2 vectors accepted. `in_ready` stays low at the third first beat until a pop frees 4 slots. No `err`.
- Gap of 5 idle cycles between beats 1 and 2 → `chain_enable`=0 and `chain_index`=0 during the gap. Indices resume at 2.
- Push and pop in the same cycle with FIFO occupancy 3 → occupancy stays 3. FIFO order preserved.
- Flagged result injected while `IDLE` → dropped, `err`=1 and stays 1 until `rst_n` is pulsed.
- `WSEQ_TIMEOUT_EN`, `TIMEOUT`=16, vector issued but chain never returns results → `err` set 16 cycles after the last issue. `pending`=0, `busy`=0, and `in_ready` returns high.
